// File: rtl/systolic_stream_driver.sv
// Host-side sequencer for systolic_wrapper: replays a sample buffer as xin on a fixed
// donext cadence and returns each captured yout sign-extended and tagged with its index.
module systolic_stream_driver #(
   parameter int N      = 8,
   parameter int DW     = 16,
   parameter int PERIOD = 30,
   parameter int ROUNDS = 3,
   localparam int AW    = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk30x,
   input  logic          rst,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] xin,
   output logic          donext,
   input  logic [DW-1:0] yout,
   output logic          res_valid,
   output logic [31:0]   res_data,
   output logic [AW-1:0] res_tag
);

   localparam int S  = ROUNDS * N;
   localparam int KW = (S > 1) ? $clog2(S) : 1;
   localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   typedef enum logic [2:0] {IDLE, WAIT, STROBE, FLUSH, FINISH} state_t;

   state_t        state_reg, state_next;
   logic [PW-1:0] phase_reg, phase_next;
   logic [KW-1:0] k_reg, k_next;
   logic [AW-1:0] idx_reg, idx_next;
   logic [AW-1:0] tag_reg, tag_next;
   logic [DW-1:0] xin_reg, xin_next;
   logic          donext_reg, donext_next;
   logic          busy_reg, busy_next;
   logic          done_reg, done_next;
   logic          res_valid_reg, res_valid_next;
   logic [31:0]   res_data_reg, res_data_next;
   logic [AW-1:0] res_tag_reg, res_tag_next;
   logic [31:0]   yout_ext;

   logic [DW-1:0] mem [N];

   // Buffer is deliberately left out of reset so a run can be replayed after an abort.
   always_ff @(posedge clk30x) begin
      if (ld_we && !busy_reg)
         mem[ld_addr] <= ld_data;
   end

   assign yout_ext = {{(32-DW){yout[DW-1]}}, yout};

   always_ff @(posedge clk30x) begin
      if (rst) begin
         state_reg     <= IDLE;
         phase_reg     <= '0;
         k_reg         <= '0;
         idx_reg       <= '0;
         tag_reg       <= '0;
         xin_reg       <= '0;
         donext_reg    <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         res_valid_reg <= 1'b0;
         res_data_reg  <= '0;
         res_tag_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         phase_reg     <= phase_next;
         k_reg         <= k_next;
         idx_reg       <= idx_next;
         tag_reg       <= tag_next;
         xin_reg       <= xin_next;
         donext_reg    <= donext_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         res_valid_reg <= res_valid_next;
         res_data_reg  <= res_data_next;
         res_tag_reg   <= res_tag_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      phase_next     = phase_reg;
      k_next         = k_reg;
      idx_next       = idx_reg;
      tag_next       = tag_reg;
      xin_next       = xin_reg;
      donext_next    = 1'b0;
      busy_next      = busy_reg;
      done_next      = 1'b0;
      res_valid_next = 1'b0;
      res_data_next  = res_data_reg;
      res_tag_next   = res_tag_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = WAIT;
               phase_next = PW'(PERIOD - 1);
               k_next     = '0;
               idx_next   = '0;
               tag_next   = AW'(N - 2);
               busy_next  = 1'b1;
            end
         end
         WAIT, FLUSH: begin
            if (phase_reg == '0)
               state_next = (state_reg == WAIT) ? STROBE : FINISH;
            else
               phase_next = phase_reg - PW'(1);
         end
         STROBE: begin
            donext_next    = 1'b1;
            xin_next       = mem[idx_reg];
            res_data_next  = yout_ext;
            res_tag_next   = tag_reg;
            res_valid_next = (k_reg != '0);
            idx_next       = (idx_reg == AW'(N - 1)) ? '0 : idx_reg + AW'(1);
            tag_next       = (tag_reg == AW'(N - 2 + 1)) ? '0 : tag_reg + AW'(1);
            k_next         = k_reg + KW'(1);
            // The strobe cycle itself is one tick of the period, hence PERIOD-2.
            phase_next     = PW'(PERIOD - 2);
            state_next     = (k_reg == KW'(S - 1)) ? FLUSH : WAIT;
         end
         FINISH: begin
            res_valid_next = 1'b1;
            res_data_next  = yout_ext;
            res_tag_next   = tag_reg;
            done_next      = 1'b1;
            busy_next      = 1'b0;
            state_next     = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy      = busy_reg;
   assign done      = done_reg;
   assign xin       = xin_reg;
   assign donext    = donext_reg;
   assign res_valid = res_valid_reg;
   assign res_data  = res_data_reg;
   assign res_tag   = res_tag_reg;

endmodule

// File: tb/tb_systolic_stream_driver.sv
// Directed bench for systolic_stream_driver: cadence, xin replay, sign extension, tags,
// ignored start/load while busy, mid-run reset and same-cycle load+start.
module tb_systolic_stream_driver;

   logic        clk30x = 1'b0;
   logic        rst = 1'b1;
   logic        ld_we = 1'b0;
   logic [2:0]  ld_addr = '0;
   logic [15:0] ld_data = '0;
   logic        start = 1'b0;
   logic        busy, done, donext, res_valid;
   logic [15:0] xin;
   logic [15:0] yout = '0;
   logic [31:0] res_data;
   logic [2:0]  res_tag;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_mem [8];

   systolic_stream_driver #(.N(8), .DW(16), .PERIOD(30), .ROUNDS(3)) dut (
      .clk30x(clk30x), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
      .start(start), .busy(busy), .done(done), .xin(xin), .donext(donext), .yout(yout),
      .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag)
   );

   always #5 clk30x = ~clk30x;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk30x);
      #1;
   endtask

   // yout value the bench presents for capture k.
   function automatic logic [15:0] vy(input int k);
      if (k == 2) return 16'hFFFE;
      if (k == 3) return 16'h7FFF;
      return 16'(k * 32'h1357 + 32'h8000);
   endfunction

   function automatic logic [31:0] sx(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_xin"}, xin, 0);
      chk({tag, "_donext"}, donext, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_res_valid"}, res_valid, 0);
      chk({tag, "_res_data"}, res_data, 0);
      chk({tag, "_res_tag"}, res_tag, 0);
   endtask

   // One run from start; abort_k>0 resets one clock after that many strobes.
   task automatic do_run(input int abort_k, input bit inject);
      int  k, c, last, nval;
      bit  prev_dn, fin;
      k = 0; c = 0; last = 0; nval = 0; prev_dn = 0; fin = 0;
      yout  = vy(0);
      start = 1'b1;
      tick;
      start = 1'b0;
      ld_we = 1'b0;
      chk("busy_after_start", busy, 1);
      while (!fin && c < 900) begin
         tick;
         c++;
         if (inject && c == 100) begin
            start = 1'b1; ld_we = 1'b1; ld_addr = 3'd3; ld_data = 16'hABCD;
         end
         if (inject && c == 101) begin
            start = 1'b0; ld_we = 1'b0;
         end
         if (donext) begin
            chk("donext_back_to_back", prev_dn, 0);
            chk("xin", xin, exp_mem[k % 8]);
            chk("strobe_spacing", c - last, (k == 0) ? 31 : 30);
            chk("strobe_res_valid", res_valid, (k != 0));
            if (k != 0) begin
               chk("strobe_res_tag", res_tag, (k + 6) % 8);
               chk("strobe_res_data", res_data, sx(vy(k)));
               nval++;
            end
            if (k == 2) chk("sext_neg", res_data, 32'hFFFFFFFE);
            if (k == 3) chk("sext_pos", res_data, 32'h00007FFF);
            chk("strobe_busy", busy, 1);
            chk("strobe_done", done, 0);
            last = c;
            k++;
            yout = vy(k);
            if (abort_k != 0 && k == abort_k) begin
               tick;
               rst = 1'b1;
               tick;
               chk_idle_outputs("abort");
               rst = 1'b0;
               for (int i = 0; i < 40; i++) begin
                  tick;
                  chk("abort_idle_donext", donext, 0);
                  chk("abort_idle_busy", busy, 0);
               end
               return;
            end
         end else if (done) begin
            chk("flush_res_valid", res_valid, 1);
            chk("flush_res_tag", res_tag, 3'd6);
            chk("flush_res_data", res_data, sx(vy(24)));
            chk("done_delay", c - last, 30);
            chk("done_busy", busy, 0);
            chk("strobe_count", k, 24);
            chk("res_valid_count", nval + 1, 24);
            fin = 1;
         end else begin
            chk("quiet_res_valid", res_valid, 0);
            chk("quiet_busy", busy, 1);
         end
         prev_dn = donext;
      end
      if (!fin) chk("run_timeout", 0, 1);
      tick;
      chk("post_done_pulse", done, 0);
      chk("post_done_busy", busy, 0);
   endtask

   initial begin
      rst = 1'b1;
      tick; tick; tick;
      rst = 1'b0;
      chk_idle_outputs("reset");

      for (int i = 0; i < 8; i++) begin
         ld_we = 1'b1; ld_addr = 3'(i); ld_data = 16'(i + 1);
         exp_mem[i] = 16'(i + 1);
         tick;
      end
      ld_we = 1'b0;
      tick;

      do_run(0, 1'b0);          // cadence, xin 1..8 x3, sign extension, tags
      do_run(0, 1'b1);          // start + load while busy are ignored
      do_run(5, 1'b0);          // reset mid-run
      do_run(0, 1'b0);          // replay of original buffer (mem[3] still 4)

      ld_we = 1'b1; ld_addr = 3'd0; ld_data = 16'h1234;
      exp_mem[0] = 16'h1234;
      do_run(0, 1'b0);          // same-cycle load + start

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
